// File: rtl/math_challenge.sv
// Arithmetic challenge for the alarm clock: draws two random operands and collects decimal digits.
// It pulses alarm_off on a correct sum, or pulses wrong and bumps a saturating miss count otherwise.
module math_challenge #(
  parameter int unsigned MAX_OPERAND    = 49,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter bit          REGEN_ON_WRONG = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alarm_on,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic [6:0] question_a,
  output logic [6:0] question_b,
  output logic [6:0] question_c,
  output logic       alarm_off,
  output logic       wrong,
  output logic       asking,
  output logic [3:0] wrong_count
);

  typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, ASK, CHECK, DONE} state_t;

  localparam logic [5:0] MAX_OP = MAX_OPERAND[5:0];

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  qa_q, qa_d, qb_q, qb_d, qc_q, qc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  wcnt_q, wcnt_d;

  logic [5:0]  cand;
  logic        cand_ok;
  logic [10:0] qc_ext;
  logic        digit_ok;
  logic [7:0]  sum;
  logic        correct;

  // Free-running Fibonacci LFSR, taps 16/14/13/11.
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand     = lfsr_q[5:0];
  assign cand_ok  = (cand <= MAX_OP);
  assign qc_ext   = ({4'd0, qc_q} * 11'd10) + {7'd0, digit};
  assign digit_ok = digit_valid && (digit <= 4'd9) && (cnt_q != 2'd3) && (qc_ext <= 11'd127);
  assign sum      = {1'b0, qa_q} + {1'b0, qb_q};
  assign correct  = (cnt_q != 2'd0) && ({1'b0, qc_q} == sum);

  always_comb begin
    state_d   = state_q;
    qa_d      = qa_q;
    qb_d      = qb_q;
    qc_d      = qc_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    alarm_off = 1'b0;
    wrong     = 1'b0;
    asking    = 1'b0;

    case (state_q)
      IDLE: begin
        if (alarm_on) begin
          state_d = GEN_A;
          wcnt_d  = 4'd0;
        end
      end
      GEN_A: begin
        if (cand_ok) begin
          qa_d    = {1'b0, cand};
          state_d = GEN_B;
        end
      end
      GEN_B: begin
        if (cand_ok) begin
          qb_d    = {1'b0, cand};
          qc_d    = 7'd0;
          cnt_d   = 2'd0;
          state_d = ASK;
        end
      end
      ASK: begin
        asking = 1'b1;
        if (clear) begin
          qc_d  = 7'd0;
          cnt_d = 2'd0;
        end else if (enter) begin
          state_d = CHECK;
        end else if (digit_ok) begin
          qc_d  = qc_ext[6:0];
          cnt_d = cnt_q + 2'd1;
        end
      end
      CHECK: begin
        if (correct) begin
          alarm_off = 1'b1;
          state_d   = DONE;
        end else begin
          wrong = 1'b1;
          if (wcnt_q != 4'hF) wcnt_d = wcnt_q + 4'd1;
          qc_d    = 7'd0;
          cnt_d   = 2'd0;
          state_d = REGEN_ON_WRONG ? GEN_A : ASK;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Dropping alarm_on outside IDLE abandons the question without any verdict pulse.
    if (state_q != IDLE && !alarm_on) begin
      state_d   = IDLE;
      qa_d      = 7'd0;
      qb_d      = 7'd0;
      qc_d      = 7'd0;
      cnt_d     = 2'd0;
      wcnt_d    = wcnt_q;
      alarm_off = 1'b0;
      wrong     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      qa_q    <= 7'd0;
      qb_q    <= 7'd0;
      qc_q    <= 7'd0;
      cnt_q   <= 2'd0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      qc_q    <= qc_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign question_a  = qa_q;
  assign question_b  = qb_q;
  assign question_c  = qc_q;
  assign wrong_count = wcnt_q;

endmodule

// File: tb/tb_math_challenge.sv
// Bench for math_challenge: three instances (default, MAX_OPERAND=63, MAX_OPERAND=5 without regeneration)
// share one stimulus stream; each scenario checks one instance against a rejection-sampling model.
module tb_math_challenge;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       alarm_on = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;

  logic [6:0] qa [3];
  logic [6:0] qb [3];
  logic [6:0] qc [3];
  logic       ao [3];
  logic       wr [3];
  logic       ask [3];
  logic [3:0] wc [3];

  int total = 0;
  int bad   = 0;
  logic [15:0] lfsr_m;

  math_challenge u_d49 (
    .clock(clock), .reset(reset), .alarm_on(alarm_on), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .question_a(qa[0]), .question_b(qb[0]), .question_c(qc[0]),
    .alarm_off(ao[0]), .wrong(wr[0]), .asking(ask[0]), .wrong_count(wc[0]));

  math_challenge #(.MAX_OPERAND(63)) u_d63 (
    .clock(clock), .reset(reset), .alarm_on(alarm_on), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .question_a(qa[1]), .question_b(qb[1]), .question_c(qc[1]),
    .alarm_off(ao[1]), .wrong(wr[1]), .asking(ask[1]), .wrong_count(wc[1]));

  math_challenge #(.MAX_OPERAND(5), .REGEN_ON_WRONG(1'b0)) u_d5 (
    .clock(clock), .reset(reset), .alarm_on(alarm_on), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .question_a(qa[2]), .question_b(qb[2]), .question_c(qc[2]),
    .alarm_off(ao[2]), .wrong(wr[2]), .asking(ask[2]), .wrong_count(wc[2]));

  always #5 clock = ~clock;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference random source: same sequence as the design, advancing once per clock.
  always @(posedge clock or negedge reset) begin
    if (!reset) lfsr_m <= SEED;
    else        lfsr_m <= step(lfsr_m);
  end

  // Rejection sampling from the LFSR value seen on the first generation cycle.
  task automatic predict(input logic [15:0] l0, input int mx, output int a, output int b,
                         output int na, output int nall);
    logic [15:0] l = l0;
    int n = 0;
    while (int'(l[5:0]) > mx && n < 5000) begin l = step(l); n++; end
    a = int'(l[5:0]); n++; na = n; l = step(l);
    while (int'(l[5:0]) > mx && n < 5000) begin l = step(l); n++; end
    b = int'(l[5:0]); n++; nall = n;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic abort_all();
    alarm_on = 1'b0; digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
    tick();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic start_alarm(output logic [15:0] l);
    alarm_on = 1'b1;
    tick();
    l = lfsr_m;
  endtask

  task automatic wait_ask(input int sel, input int already, output int cyc);
    cyc = already;
    while (ask[sel] !== 1'b1 && cyc < 400) begin tick(); cyc++; end
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1; digit = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic type_number(input int v);
    if (v >= 10) press(4'(v / 10));
    press(4'(v % 10));
  endtask

  task automatic do_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    logic [15:0] l;
    for (int s = 0; s < 3; s++) begin
      total++; if ({qa[s], qb[s], qc[s], ao[s], wr[s], ask[s], wc[s]} !== 28'd0) begin bad++;
        $display("FAIL reset_hold dut%0d: outputs=%h want 0", s, {qa[s], qb[s], qc[s], ao[s], wr[s], ask[s], wc[s]}); end
    end
    reset = 1'b1;
    tick();
    start_alarm(l);
    wait_ask(0, 0, cyc);
    press(4'd1);
    total++; if (qc[0] !== 7'd1) begin bad++; $display("FAIL pre_reset_digit: got %0d want 1", qc[0]); end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++; if ({qa[s], qb[s], qc[s], ao[s], wr[s], ask[s], wc[s]} !== 28'd0) begin bad++;
        $display("FAIL async_reset dut%0d: outputs=%h want 0", s, {qa[s], qb[s], qc[s], ao[s], wr[s], ask[s], wc[s]}); end
    end
    @(negedge clock);
    alarm_on = 1'b0;
    reset = 1'b1;
    tick();
    total++; if ({ask[0], qa[0], qb[0], qc[0]} !== 22'd0) begin bad++;
      $display("FAIL post_reset_idle: got %h want 0", {ask[0], qa[0], qb[0], qc[0]}); end
  endtask

  task automatic test_gen();
    logic [15:0] l;
    int a, b, na, nall, cyc;
    abort_all();
    start_alarm(l);
    predict(l, 49, a, b, na, nall);
    tick();
    total++; if (qa[1] !== 7'(l[5:0])) begin bad++; $display("FAIL gen63_a: got %0d want %0d", qa[1], l[5:0]); end
    total++; if (ask[1] !== 1'b0) begin bad++; $display("FAIL gen63_early_ask: got %0b want 0", ask[1]); end
    tick();
    total++; if (qb[1] !== 7'(step(l) & 16'h3F)) begin bad++;
      $display("FAIL gen63_b: got %0d want %0d", qb[1], step(l) & 16'h3F); end
    total++; if (ask[1] !== 1'b1) begin bad++; $display("FAIL gen63_ask_lat3: got %0b want 1", ask[1]); end
    wait_ask(0, 2, cyc);
    total++; if (cyc !== nall) begin bad++; $display("FAIL gen49_latency: got %0d want %0d", cyc, nall); end
    total++; if (qa[0] !== a[6:0] || qb[0] !== b[6:0]) begin bad++;
      $display("FAIL gen49_ops: got %0d,%0d want %0d,%0d", qa[0], qb[0], a, b); end
    total++; if (qc[0] !== 7'd0 || wc[0] !== 4'd0) begin bad++;
      $display("FAIL gen49_c_wc: got %0d,%0d want 0,0", qc[0], wc[0]); end
  endtask

  task automatic test_correct();
    logic [15:0] l;
    int a, b, na, nall, cyc, sum;
    for (int it = 0; it < 3; it++) begin
      abort_all();
      start_alarm(l);
      predict(l, 49, a, b, na, nall);
      wait_ask(0, 0, cyc);
      total++; if (cyc !== nall || qa[0] !== a[6:0] || qb[0] !== b[6:0]) begin bad++;
        $display("FAIL ok_setup: got cyc=%0d ops=%0d,%0d want %0d,%0d,%0d", cyc, qa[0], qb[0], nall, a, b); end
      sum = a + b;
      if (sum >= 10) begin
        press(4'(sum / 10));
        total++; if (qc[0] !== 7'(sum / 10)) begin bad++; $display("FAIL ok_first_digit: got %0d want %0d", qc[0], sum / 10); end
      end
      press(4'(sum % 10));
      total++; if (qc[0] !== sum[6:0]) begin bad++; $display("FAIL ok_typed: got %0d want %0d", qc[0], sum); end
      do_enter();
      total++; if (ao[0] !== 1'b1 || wr[0] !== 1'b0) begin bad++;
        $display("FAIL ok_pulse: got off=%0b wrong=%0b want 1,0", ao[0], wr[0]); end
      tick();
      total++; if (ao[0] !== 1'b0 || ask[0] !== 1'b0 || qa[0] !== a[6:0]) begin bad++;
        $display("FAIL ok_done: got off=%0b ask=%0b a=%0d want 0,0,%0d", ao[0], ask[0], qa[0], a); end
      do_enter();
      total++; if (ao[0] !== 1'b0 || wr[0] !== 1'b0) begin bad++;
        $display("FAIL ok_done_quiet: got off=%0b wrong=%0b want 0,0", ao[0], wr[0]); end
      alarm_on = 1'b0;
      tick();
      total++; if ({qa[0], qb[0], qc[0], ask[0]} !== 22'd0) begin bad++;
        $display("FAIL ok_idle: got %h want 0", {qa[0], qb[0], qc[0], ask[0]}); end
    end
  endtask

  task automatic test_wrong();
    logic [15:0] l;
    int a, b, na, nall, cyc;
    abort_all();
    start_alarm(l);
    predict(l, 49, a, b, na, nall);
    wait_ask(0, 0, cyc);
    type_number(a + b + 1);
    do_enter();
    total++; if (wr[0] !== 1'b1 || ao[0] !== 1'b0) begin bad++;
      $display("FAIL wrong_pulse: got wrong=%0b off=%0b want 1,0", wr[0], ao[0]); end
    tick();
    total++; if (wc[0] !== 4'd1 || qc[0] !== 7'd0 || wr[0] !== 1'b0) begin bad++;
      $display("FAIL wrong_after: got wc=%0d c=%0d wrong=%0b want 1,0,0", wc[0], qc[0], wr[0]); end
    l = lfsr_m;
    predict(l, 49, a, b, na, nall);
    wait_ask(0, 0, cyc);
    total++; if (cyc !== nall || qa[0] !== a[6:0] || qb[0] !== b[6:0]) begin bad++;
      $display("FAIL wrong_regen: got cyc=%0d ops=%0d,%0d want %0d,%0d,%0d", cyc, qa[0], qb[0], nall, a, b); end
    do_enter();
    total++; if (wr[0] !== 1'b1) begin bad++; $display("FAIL empty_enter_pulse: got %0b want 1", wr[0]); end
    tick();
    total++; if (wc[0] !== 4'd2) begin bad++; $display("FAIL empty_enter_count: got %0d want 2", wc[0]); end
    wait_ask(0, 0, cyc);
    press(4'd5);
    clear = 1'b1; enter = 1'b1;
    tick();
    clear = 1'b0; enter = 1'b0;
    total++; if (qc[0] !== 7'd0 || ask[0] !== 1'b1 || wr[0] !== 1'b0 || ao[0] !== 1'b0) begin bad++;
      $display("FAIL clear_beats_enter: got c=%0d ask=%0b wrong=%0b off=%0b want 0,1,0,0", qc[0], ask[0], wr[0], ao[0]); end
  endtask

  task automatic test_digits();
    logic [15:0] l;
    int cyc;
    abort_all();
    start_alarm(l);
    wait_ask(0, 0, cyc);
    press(4'd11); press(4'd1); press(4'd2); press(4'd7);
    total++; if (qc[0] !== 7'd127) begin bad++; $display("FAIL digit_127: got %0d want 127", qc[0]); end
    do_clear();
    total++; if (qc[0] !== 7'd0) begin bad++; $display("FAIL digit_clear: got %0d want 0", qc[0]); end
    press(4'd1); press(4'd2); press(4'd8);
    total++; if (qc[0] !== 7'd12) begin bad++; $display("FAIL digit_128_drop: got %0d want 12", qc[0]); end
    press(4'd15);
    total++; if (qc[0] !== 7'd12) begin bad++; $display("FAIL digit_15_ignored: got %0d want 12", qc[0]); end
    do_clear();
    press(4'd1); press(4'd0); press(4'd0); press(4'd5);
    total++; if (qc[0] !== 7'd100) begin bad++; $display("FAIL digit_fourth: got %0d want 100", qc[0]); end
  endtask

  task automatic test_regen_off();
    logic [15:0] l;
    int a, b, na, nall, cyc;
    abort_all();
    start_alarm(l);
    predict(l, 5, a, b, na, nall);
    wait_ask(2, 0, cyc);
    total++; if (cyc !== nall || qa[2] !== a[6:0] || qb[2] !== b[6:0] || wc[2] !== 4'd0) begin bad++;
      $display("FAIL d5_setup: got cyc=%0d ops=%0d,%0d wc=%0d want %0d,%0d,%0d,0", cyc, qa[2], qb[2], wc[2], nall, a, b); end
    press(4'd9); press(4'd9);
    do_enter();
    total++; if (wr[2] !== 1'b1 || ao[2] !== 1'b0) begin bad++;
      $display("FAIL d5_wrong: got wrong=%0b off=%0b want 1,0", wr[2], ao[2]); end
    tick();
    total++; if (ask[2] !== 1'b1 || qa[2] !== a[6:0] || qb[2] !== b[6:0] || qc[2] !== 7'd0 || wc[2] !== 4'd1) begin bad++;
      $display("FAIL d5_reask: got ask=%0b ops=%0d,%0d c=%0d wc=%0d want 1,%0d,%0d,0,1", ask[2], qa[2], qb[2], qc[2], wc[2], a, b); end
    for (int i = 0; i < 17; i++) begin
      do_enter();
      total++; if (wr[2] !== 1'b1) begin bad++; $display("FAIL d5_rep_wrong%0d: got %0b want 1", i, wr[2]); end
      tick();
      if (i == 12) begin
        total++; if (wc[2] !== 4'd14) begin bad++; $display("FAIL d5_count14: got %0d want 14", wc[2]); end
      end
    end
    total++; if (wc[2] !== 4'd15) begin bad++; $display("FAIL d5_saturate: got %0d want 15", wc[2]); end
    abort_all();
    start_alarm(l);
    total++; if (wc[2] !== 4'd0) begin bad++; $display("FAIL d5_count_cleared: got %0d want 0", wc[2]); end
  endtask

  task automatic test_max5_abort();
    logic [15:0] l;
    int a, b, na, nall, cyc;
    for (int it = 0; it < 200; it++) begin
      abort_all();
      start_alarm(l);
      predict(l, 5, a, b, na, nall);
      wait_ask(2, 0, cyc);
      total++; if (cyc !== nall || qa[2] !== a[6:0] || qb[2] !== b[6:0]) begin bad++;
        $display("FAIL max5_model%0d: got cyc=%0d ops=%0d,%0d want %0d,%0d,%0d", it, cyc, qa[2], qb[2], nall, a, b); end
      total++; if (qa[2] > 7'd5 || qb[2] > 7'd5) begin bad++;
        $display("FAIL max5_range%0d: got %0d,%0d want <=5", it, qa[2], qb[2]); end
    end
    abort_all();
    start_alarm(l);
    predict(l, 5, a, b, na, nall);
    repeat (na) tick();
    total++; if (qa[2] !== a[6:0] || ask[2] !== 1'b0) begin bad++;
      $display("FAIL genb_entry: got a=%0d ask=%0b want %0d,0", qa[2], ask[2], a); end
    alarm_on = 1'b0;
    tick();
    total++; if ({qa[2], qb[2], qc[2], ao[2], wr[2], ask[2]} !== 24'd0) begin bad++;
      $display("FAIL genb_abort: got %h want 0", {qa[2], qb[2], qc[2], ao[2], wr[2], ask[2]}); end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_gen();
    test_correct();
    test_wrong();
    test_digits();
    test_regen_off();
    test_max5_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
